// File: rtl/hack_pkg.sv
// Shared Hack definitions: RAM geometry and the RAM loader state encoding.
package hack_pkg;

  localparam int HACK_RAM_DEPTH = 16384;
  localparam int HACK_WORD_W    = 16;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_WRITE   = 4'd5,
    ST_CSUM_HI = 4'd6,
    ST_CSUM_LO = 4'd7,
    ST_DONE    = 4'd8,
    ST_ERROR   = 4'd9
  } loader_state_t;

  // States in which the loader accepts a stream byte.
  function automatic logic takes_byte(loader_state_t s);
    return (s == ST_LEN_HI)  || (s == ST_LEN_LO)  ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO) ||
           (s == ST_CSUM_HI) || (s == ST_CSUM_LO);
  endfunction

endpackage

// File: rtl/hack_byte_to_word.sv
// Big-endian byte pair assembler: holds the HI byte, presents {hi, byte} combinationally
// and pulses word_valid the cycle after a LO byte is taken.
module hack_byte_to_word
  import hack_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hi_en,
  input  logic                   lo_en,
  input  logic [7:0]             byte_in,
  output logic [HACK_WORD_W-1:0] word_next,
  output logic                   word_valid
);

  logic [7:0] hi_q, hi_d;
  logic       valid_q, valid_d;

  always_comb begin
    hi_d    = hi_en ? byte_in : hi_q;
    valid_d = lo_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q    <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      valid_q <= valid_d;
    end
  end

  assign word_next  = {hi_q, byte_in};
  assign word_valid = valid_q;

endmodule

// File: rtl/hack_ram_loader.sv
// Hack RAM loader: frames a byte stream into length-prefixed 16-bit words and writes them
// to consecutive RAM addresses. Define HACK_LOADER_CHECKSUM_EN to require a trailing checksum.
module hack_ram_loader
  import hack_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = HACK_RAM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_write_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_in_data,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  loader_state_t state_q, state_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   idx_q, idx_d;
  logic          in_ready_q, in_ready_d;
  logic          wr_q, wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [15:0]   sum_q, sum_d;
`endif

  logic        xfer;
  logic        hi_en, lo_en;
  logic [15:0] word_next;
  logic        word_valid;

  assign xfer = in_valid && in_ready_q;

  hack_byte_to_word u_b2w (
    .clk        (clk),
    .rst        (rst),
    .hi_en      (hi_en),
    .lo_en      (lo_en),
    .byte_in    (in_byte),
    .word_next  (word_next),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    hi_en   = 1'b0;
    lo_en   = 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LEN_HI;
          idx_d   = 16'h0000;
`ifdef HACK_LOADER_CHECKSUM_EN
          sum_d   = 16'h0000;
`endif
        end
      end
      ST_LEN_HI: if (xfer) begin hi_en = 1'b1; state_d = ST_LEN_LO; end
      ST_LEN_LO: begin
        if (xfer) begin
          lo_en = 1'b1;
          n_d   = word_next;
          // Length is validated on the full 16-bit value before any write.
          if ({1'b0, word_next} > MAX_LEN)
            state_d = ST_ERROR;
          else if (word_next == 16'h0000)
`ifdef HACK_LOADER_CHECKSUM_EN
            state_d = ST_CSUM_HI;
`else
            state_d = ST_DONE;
`endif
          else
            state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (xfer) begin hi_en = 1'b1; state_d = ST_DATA_LO; end
      ST_DATA_LO: if (xfer) begin lo_en = 1'b1; state_d = ST_WRITE; end
      ST_WRITE: begin
        if (word_valid) idx_d = idx_q + 16'd1;
`ifdef HACK_LOADER_CHECKSUM_EN
        sum_d = sum_q + data_q;
        state_d = (idx_q == n_q - 16'd1) ? ST_CSUM_HI : ST_DATA_HI;
`else
        state_d = (idx_q == n_q - 16'd1) ? ST_DONE : ST_DATA_HI;
`endif
      end
`ifdef HACK_LOADER_CHECKSUM_EN
      ST_CSUM_HI: if (xfer) begin hi_en = 1'b1; state_d = ST_CSUM_LO; end
      ST_CSUM_LO: begin
        if (xfer) begin
          lo_en   = 1'b1;
          state_d = (word_next == sum_q) ? ST_DONE : ST_ERROR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state flop.
    in_ready_d = takes_byte(state_d);
    wr_d       = (state_d == ST_WRITE);
    busy_d     = in_ready_d || wr_d;
    addr_d     = wr_d ? (BASE_ADDR + idx_q) : 16'h0000;
    data_d     = wr_d ? word_next : 16'h0000;
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= 16'h0000;
      idx_q      <= 16'h0000;
      in_ready_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 16'h0000;
      data_q     <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
      sum_q      <= 16'h0000;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef HACK_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_write_en = wr_q;
  assign mem_addr     = addr_q;
  assign mem_in_data  = data_q;
  assign busy         = busy_q;
  assign cpu_hold     = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_hack_ram_loader.sv
// Directed bench for hack_ram_loader: frame-level model of expected RAM writes and outcome.
module tb_hack_ram_loader;

  localparam logic [15:0] BASE = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_byte;
  logic        in_ready, mem_write_en, busy, cpu_hold, done, error;
  logic [15:0] mem_addr, mem_in_data;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  logic [15:0] frame_q[$];
  logic [15:0] ram [0:63];

  hack_ram_loader #(.BASE_ADDR(BASE), .MAX_WORDS(16384)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_in_data  (mem_in_data),
    .busy         (busy),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (mem_write_en === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_in_data);
      end else begin
        check("write_addr", mem_addr, exp_addr_q.pop_front());
        check("write_data", mem_in_data, exp_data_q.pop_front());
      end
      check("ready_during_write", in_ready, 0);
      check("busy_during_write", busy, 1);
      ram[mem_addr[5:0]] = mem_in_data;
    end else begin
      check("idle_addr_zero", mem_addr, 0);
      check("idle_data_zero", mem_in_data, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 64; i++) ram[i] = 16'h0000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    w = 0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got in_ready 0 for 50 cycles expected 1 (byte %0h)", b);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  function automatic logic [15:0] model_sum();
    logic [15:0] s;
    s = 16'h0000;
    foreach (frame_q[i]) s = s + frame_q[i];
    return s;
  endfunction

  // Sends a complete frame from frame_q and derives the expected outcome from the framing rules.
  task automatic send_frame(input logic [15:0] n, input int gap, input logic [15:0] csum,
                            output logic exp_done, output logic exp_err);
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
    if (n > 16384) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      exp_addr_q.push_back(BASE + 16'(i));
      exp_data_q.push_back(frame_q[i]);
      send_byte(frame_q[i][15:8], gap);
      send_byte(frame_q[i][7:0], gap);
    end
`ifdef HACK_LOADER_CHECKSUM_EN
    send_byte(csum[15:8], gap);
    send_byte(csum[7:0], gap);
    exp_done = (csum == model_sum());
    exp_err  = !exp_done;
`else
    exp_done = 1'b1;
    exp_err  = 1'b0;
    if (csum != model_sum()) exp_done = 1'b1;
`endif
  endtask

  task automatic check_end(input string tag, input logic exp_done, input logic exp_err);
    int w;
    w = 0;
    while (!(done || error) && w < 20) begin
      tick();
      w++;
    end
    if (!(done || error)) begin
      checks++;
      errors++;
      $display("FAIL %s_end_timeout: got done=0 error=0 expected completion", tag);
    end
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_writes_drained"}, exp_addr_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ed, ee;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    clear_ram();
    tick(); tick();
    rst = 1'b0;
    check("reset_in_ready", in_ready, 0);
    check("reset_write_en", mem_write_en, 0);
    check("reset_busy", busy, 0);
    check("reset_cpu_hold", cpu_hold, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    tick();
    check("idle_no_ready", in_ready, 0);

    // 1: two-word frame back to back
    pulse_start();
    check("t1_busy_after_start", busy, 1);
    check("t1_hold_after_start", cpu_hold, 1);
    check("t1_ready_after_start", in_ready, 1);
    frame_q = '{16'h1234, 16'hABCD};
    send_frame(16'h0002, 0, 16'hBE01, ed, ee);
    check_end("t1", ed, ee);
    check("t1_done_lit", done, 1);
    check("t1_ram0", ram[0], 16'h1234);
    check("t1_ram1", ram[1], 16'hABCD);

    // 2: same frame with 3-cycle gaps
    clear_ram();
    pulse_start();
    check("t2_done_cleared", done, 0);
    send_frame(16'h0002, 3, 16'hBE01, ed, ee);
    check_end("t2", ed, ee);
    check("t2_ram0", ram[0], 16'h1234);
    check("t2_ram1", ram[1], 16'hABCD);

    // 3: empty image
    pulse_start();
    frame_q = {};
    send_frame(16'h0000, 0, 16'h0000, ed, ee);
    tick(); tick();
    check("t3_done_lit", done, 1);
    check_end("t3", ed, ee);

    // 4: oversize length, then restart clears error
    pulse_start();
    send_frame(16'h4001, 0, 16'h0000, ed, ee);
    check_end("t4", ed, ee);
    check("t4_error_lit", error, 1);
    pulse_start();
    check("t4_error_cleared", error, 0);
    check("t4_busy_again", busy, 1);
    send_frame(16'hFFFF, 1, 16'h0000, ed, ee);
    check_end("t4b", ed, ee);

    // three words with wrapping checksum
    clear_ram();
    pulse_start();
    frame_q = '{16'h0001, 16'hFFFF, 16'h8000};
    send_frame(16'h0003, 1, 16'h8000, ed, ee);
    check_end("t4c", ed, ee);
    check("t4c_ram2", ram[2], 16'h8000);

    // 5: reset right after the first word is written
    clear_ram();
    pulse_start();
    exp_addr_q.push_back(BASE);
    exp_data_q.push_back(16'h1234);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    check("t5_write_strobe", mem_write_en, 1);
    check("t5_write_addr", mem_addr, 16'h0000);
    check("t5_write_data", mem_in_data, 16'h1234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_ready", in_ready, 0);
    check("t5_rst_write", mem_write_en, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_hold", cpu_hold, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_error", error, 0);
    check("t5_ram0_kept", ram[0], 16'h1234);
    check("t5_writes_drained", exp_addr_q.size(), 0);

`ifdef HACK_LOADER_CHECKSUM_EN
    // 6: checksum accept and reject
    clear_ram();
    pulse_start();
    frame_q = '{16'h0005};
    send_frame(16'h0001, 0, 16'h0005, ed, ee);
    check_end("t6a", ed, ee);
    check("t6a_done_lit", done, 1);
    pulse_start();
    send_frame(16'h0001, 0, 16'h0006, ed, ee);
    check_end("t6b", ed, ee);
    check("t6b_error_lit", error, 1);
    check("t6b_ram0", ram[0], 16'h0005);
`endif

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
